// File: rtl/param_def.sv
// Code-rate encodings shared by the encoder/decoder datapath.
package param_def;
  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;
endpackage

// File: rtl/viterbi_pkg.sv
// Frame geometry and loader state encoding for the slicer front end.
package viterbi_pkg;
  import param_def::*;

  localparam int ENC_FRAME_W = 320;
  localparam int DEC_FRAME_W = 384;

  localparam logic [5:0] ENC_FRAME_BYTES = 6'd40;
  localparam logic [5:0] DEC_BYTES_R2    = 6'd32;
  localparam logic [5:0] DEC_BYTES_R3    = 6'd48;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} loader_state_t;

  function automatic logic [5:0] frame_bytes(input logic mode, input logic rate);
    if (!mode) return ENC_FRAME_BYTES;
    return (rate == CODE_RATE_3) ? DEC_BYTES_R3 : DEC_BYTES_R2;
  endfunction
endpackage

// File: rtl/load_timer.sv
// Idle-gap down-counter for the loader; only built when LOAD_TIMEOUT_EN is defined.
// expire pulses after CYCLES-1 consecutive running cycles without a clear.
`ifdef LOAD_TIMEOUT_EN
module load_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);
  localparam int W = $clog2(CYCLES);
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] remain;

  assign expire = run && !clear && (remain == W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          remain <= RELOAD;
    else if (clear || !run || expire) remain <= RELOAD;
    else                              remain <= remain - W'(1);
  end
endmodule
`endif

// File: rtl/frame_loader.sv
// Byte-stream loader assembling encoder/decoder frames MSB first for the slicer.
// Optional idle-gap timeout is enabled with LOAD_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for the first byte of a frame
//   LOAD  | collecting bytes until the mode/rate byte count is reached
//   FULL  | frame held stable until acknowledged
module frame_loader
  import param_def::*;
  import viterbi_pkg::*;
#(
  parameter int ENC_FRAME_W    = viterbi_pkg::ENC_FRAME_W,
  parameter int DEC_FRAME_W    = viterbi_pkg::DEC_FRAME_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_mode,
  input  logic                   i_code_rate,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_flush,
  input  logic                   i_frame_ack,
  output logic [ENC_FRAME_W-1:0] o_encoder_data_frame,
  output logic [DEC_FRAME_W-1:0] o_decoder_data_frame,
  output logic                   o_frame_valid,
  output logic                   o_frame_mode,
  output logic                   o_frame_rate,
  output logic                   o_timeout
);
  loader_state_t state, state_next;
  logic [5:0] count;
  logic [5:0] target;
  logic [8:0] enc_pos;
  logic [8:0] dec_pos;
  logic       hs;
  logic       flush_load;
  logic       accept;
  logic       last;
  logic       expire;

  assign hs         = i_valid & o_ready;
  assign flush_load = i_flush & (state == LOAD);
  assign accept     = hs & ~flush_load;
  assign target     = frame_bytes(o_frame_mode, o_frame_rate);
  assign last       = (state == LOAD) & accept & (count == target - 6'd1);
  assign enc_pos    = 9'(ENC_FRAME_W - 1) - {count, 3'b000};
  assign dec_pos    = (o_frame_rate == CODE_RATE_3) ? 9'(DEC_FRAME_W - 1) - {count, 3'b000}
                                                    : 9'd255 - {count, 3'b000};

`ifdef LOAD_TIMEOUT_EN
  load_timer #(.CYCLES(TIMEOUT_CYCLES)) u_load_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state == LOAD),
    .clear  (hs | flush_load),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_timeout <= 1'b0;
    else     o_timeout <= expire;
  end
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: begin
        if (flush_load || expire) state_next = IDLE;
        else if (last)            state_next = FULL;
      end
      FULL: if (i_frame_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ready is forced low during reset, not just from the reset state
  always_comb begin
    o_ready       = ~rst & (state != FULL);
    o_frame_valid = (state == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count                <= '0;
      o_encoder_data_frame <= '0;
      o_decoder_data_frame <= '0;
      o_frame_mode         <= 1'b0;
      o_frame_rate         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          o_frame_mode <= i_mode;
          o_frame_rate <= i_code_rate;
          count        <= 6'd1;
          if (!i_mode)
            o_encoder_data_frame <= {i_data, {(ENC_FRAME_W-8){1'b0}}};
          else if (i_code_rate == CODE_RATE_3)
            o_decoder_data_frame <= {i_data, {(DEC_FRAME_W-8){1'b0}}};
          else
            o_decoder_data_frame <= {{(DEC_FRAME_W-256){1'b0}}, i_data, 248'd0};
        end
        LOAD: begin
          if (flush_load || expire) begin
            count <= '0;
          end else if (accept) begin
            if (!o_frame_mode) o_encoder_data_frame[enc_pos -: 8] <= i_data;
            else               o_decoder_data_frame[dec_pos -: 8] <= i_data;
            if (count != target) count <= count + 6'd1;
          end
        end
        FULL: if (i_frame_ack) count <= '0;
        default: count <= '0;
      endcase
    end
  end
endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream stage of the slicer. Accepts a byte stream with a valid/ready handshake.
- Assembles either the 320-bit encoder frame or the 384-bit decoder frame, MSB first.
- Holds the completed frame stable, with o_frame_valid high, until the downstream controller acknowledges it.
- Drives the slicer's frame inputs and its start condition.

Parameters:
- ENC_FRAME_W, 320, encoder frame width in bits (40 bytes)
- DEC_FRAME_W, 384, decoder frame width in bits (48 bytes at rate 1/3; 32 bytes at rate 1/2)
- TIMEOUT_CYCLES, 1024, idle-gap limit; used only with LOAD_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_mode  in  1  0 = encode frame, 1 = decode frame; sampled with the first byte
- i_code_rate  in  1  CODE_RATE_2 / CODE_RATE_3 (param_def); sampled with the first byte
- i_data  in  8  input byte
- i_valid  in  1  byte present
- o_ready  out  1  loader can accept a byte
- i_flush  in  1  synchronous abort of a partial frame
- i_frame_ack  in  1  downstream has consumed the frame
- o_encoder_data_frame  out  320  assembled encoder frame
- o_decoder_data_frame  out  384  assembled decoder frame
- o_frame_valid  out  1  frame complete and stable
- o_frame_mode  out  1  latched mode of the held frame
- o_frame_rate  out  1  latched code rate of the held frame
- o_timeout  out  1  one-cycle pulse; LOAD_TIMEOUT_EN only

Behaviour:
- Reset (async, rst=1):
  - state IDLE, byte count 0.
  - Both frames all-zero.
  - o_frame_valid, o_frame_mode, o_frame_rate, o_timeout = 0.
  - o_ready = 0 while rst is high.
- States:
  - IDLE: o_ready=1. A handshake (i_valid & o_ready) latches i_mode and i_code_rate, clears the target frame register, writes the byte, sets count=1, and moves to LOAD.
  - LOAD: o_ready=1. Each handshake writes a byte and increments count. Rate/mode changes on the inputs are ignored mid-frame.
  - FULL: o_ready=0, o_frame_valid=1, frames frozen. i_frame_ack → IDLE. Frame contents are retained after ack; o_frame_valid drops.
- Target byte count N:
  - encode: 40
  - decode, rate 1/2: 32
  - decode, rate 1/3: 48
- Placement (byte k, k=0 first):
  - encode: o_encoder_data_frame[319-8k -: 8]
  - decode rate 1/3: o_decoder_data_frame[383-8k -: 8]
  - decode rate 1/2: o_decoder_data_frame[255-8k -: 8]; bits [383:256] read 0
  - The non-target frame is untouched.
- Latency:
  - The handshake accepting byte N-1 moves the state to FULL on that edge.
  - o_frame_valid is high in the following cycle.
  - Back-to-back input gives a 40-cycle encoder frame load.
- Count: 6-bit register, saturating at the terminal value, never wraps.
- Boundaries:
  - i_flush in LOAD → IDLE next edge; count 0; partial data discarded (frame cleared on the next first byte). i_flush has priority over a same-cycle handshake.
  - i_flush in IDLE or FULL is ignored.
  - i_frame_ack outside FULL is ignored.
  - i_valid during FULL is not accepted (ready low); the source must hold the byte.
  - rst mid-LOAD or mid-FULL: immediate return to the reset values above.
  - A single-byte frame is impossible; the N=1 case never occurs.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- Defined:
  - A gap counter runs in LOAD, clearing on every handshake.
  - Reaching TIMEOUT_CYCLES-1 consecutive cycles without a handshake → IDLE, count 0, o_timeout pulses for one cycle.
  - Flush or rst clears the counter.
- Undefined:
  - No counter is built; o_timeout is tied to 0.
  - LOAD waits indefinitely.

Decomposition:
- Shared package viterbi_pkg holds:
  - ENC_FRAME_BYTES=40, DEC_BYTES_R2=32, DEC_BYTES_R3=48
  - Frame width constants
  - Enum loader_state_t {IDLE, LOAD, FULL}
- CODE_RATE_2/CODE_RATE_3 remain in param_def.
- One natural sub-module: load_timer (gap counter with a terminal pulse), instantiated only under LOAD_TIMEOUT_EN.

Test Plan:
- Encode, 40 back-to-back bytes 0x00..0x27 → enc[319:312]=0x00, enc[7:0]=0x27; o_frame_valid high the cycle after byte 40; o_frame_mode=0; decoder frame unchanged.
- Decode, rate 1/2, 32 × 0xFF after a prior all-ones rate-1/3 frame → dec[255:0] all ones, dec[383:256]=0; valid after exactly 32 handshakes.
- Decode, rate 1/3, 48 bytes with random valid gaps; i_code_rate toggled mid-frame → o_frame_rate keeps its first-byte value; dec[383:376]=byte0.
- In FULL, hold i_valid=1 for 10 cycles, then ack → o_ready=0 throughout; byte accepted only in the cycle after ack; no data corruption.
- Flush at byte 17, then a 40-byte encoder frame → the result contains only new bytes. rst asserted mid-load at byte 5 → all outputs 0 without waiting for a clock edge.
- LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16: stop after byte 3 → o_timeout pulses once, state IDLE, next byte treated as byte 0.
